// File: rtl/kf76489_host_writer_pkg.sv
// kf76489_writer_pkg: shared types and helpers for the KF76489 host writer.
//   wr_state_e   : write-sequencer states
//   cmd_t        : decoded register-write command {channel, atten, value}
//   enc_t        : command serialised into SN76489 bytes
//   encode_cmd() : command -> byte0 / byte1 / two_byte
package kf76489_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STROBE   = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_GAP      = 3'd4
  } wr_state_e;

  // Bit positions inside a latch byte
  localparam int LATCH_BIT = 7;
  localparam int TYPE_BIT  = 4;

  localparam logic [1:0] NOISE_CH = 2'd3;

  typedef struct packed {
    logic [1:0] channel;
    logic       atten;
    logic [9:0] value;
  } cmd_t;

  typedef struct packed {
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       two_byte;
  } enc_t;

  // Latch byte carries channel/type and the low nibble; only tone
  // frequencies need the follow-up data byte with value[9:4].
  function automatic enc_t encode_cmd(input cmd_t c);
    enc_t e;
    e.byte0            = 8'h00;
    e.byte0[LATCH_BIT] = 1'b1;
    e.byte0[6:5]       = c.channel;
    e.byte0[TYPE_BIT]  = c.atten;
    if (!c.atten && (c.channel == NOISE_CH)) begin
      e.byte0[3:0] = {1'b0, c.value[2:0]};
    end else begin
      e.byte0[3:0] = c.value[3:0];
    end
    e.byte1    = {2'b00, c.value[9:4]};
    e.two_byte = !c.atten && (c.channel != NOISE_CH);
    return e;
  endfunction

endpackage

// File: rtl/kf76489_host_writer_if.sv
// kf76489_host_writer_if: command handshake plus KF76489 write bus.
//   master : the host writer (accepts commands, drives CE_N/WE_N/D_OUT)
//   slave  : its environment (command source and the sound chip)
//   cmd_valid/cmd_ready/cmd_channel/cmd_atten/cmd_value : command handshake
//   CE_N/WE_N/D_OUT/READY                               : chip write bus
//   busy/timeout_error                                  : status
interface kf76489_host_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_channel;
  logic       cmd_atten;
  logic [9:0] cmd_value;
  logic       CE_N;
  logic       WE_N;
  logic [7:0] D_OUT;
  logic       READY;
  logic       busy;
  logic       timeout_error;

  modport master (
    input  cmd_valid, cmd_channel, cmd_atten, cmd_value, READY,
    output cmd_ready, CE_N, WE_N, D_OUT, busy, timeout_error
  );

  modport slave (
    output cmd_valid, cmd_channel, cmd_atten, cmd_value, READY,
    input  cmd_ready, CE_N, WE_N, D_OUT, busy, timeout_error
  );
endinterface

// File: rtl/kf76489_host_writer_cmd_fifo.sv
// kf76489_cmd_fifo: synchronous FIFO of cmd_t entries (DEPTH power of two).
//   clock, reset (async, active-high)
//   push/push_data : write port, ignored when full
//   pop/pop_data   : read port (pop_data is the head, valid when !empty)
//   empty/full     : registered occupancy flags
//   nonempty_next  : occupancy after this cycle's push/pop
module kf76489_cmd_fifo
  import kf76489_writer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic empty,
  output logic full,
  output logic nonempty_next
);
  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign pop_data  = mem_q[rd_ptr_q];
  assign nonempty_next = (count_d != '0);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/kf76489_host_writer.sv
// kf76489_host_writer: host-side bus master for the KF76489 sound generator.
// Serialises register-write commands into SN76489 bytes and strobes them
// into the chip with CE_N/WE_N/D_OUT, waiting on READY (with timeout).
//   clock, reset (async, active-high)
//   bus (kf76489_host_writer_if.master): command handshake, chip bus, status
// Build option: KF76489_WRITER_FIFO_EN queues commands in a FIFO_DEPTH-entry
// FIFO; without it a single holding register buffers one command.
module kf76489_host_writer
  import kf76489_writer_pkg::*;
#(
  parameter int READY_MASK_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 1023,
  parameter int GAP_CYCLES        = 1,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  kf76489_host_writer_if.master  bus
);
  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > READY_MASK_CYCLES)
      ? ((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES)
      : ((READY_MASK_CYCLES > GAP_CYCLES) ? READY_MASK_CYCLES : GAP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MASK_LAST = CNT_W'(READY_MASK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  if ((READY_MASK_CYCLES < 1) || (GAP_CYCLES < 1) || (TIMEOUT_CYCLES < 1) ||
      (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
    $error("kf76489_host_writer: illegal parameter combination");
  end

  cmd_t in_cmd_s;
  cmd_t entry_cmd_s;
  enc_t enc_s;
  logic push_s, pop_s, cmd_ready_s, entry_valid_s, occupied_next_s;

  assign in_cmd_s = '{channel: bus.cmd_channel, atten: bus.cmd_atten, value: bus.cmd_value};
  assign push_s   = bus.cmd_valid & cmd_ready_s;
  assign enc_s    = encode_cmd(entry_cmd_s);

`ifdef KF76489_WRITER_FIFO_EN
  logic fifo_empty_s, fifo_full_s;

  kf76489_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clock         (clock),
    .reset         (reset),
    .push          (push_s),
    .push_data     (in_cmd_s),
    .pop           (pop_s),
    .pop_data      (entry_cmd_s),
    .empty         (fifo_empty_s),
    .full          (fifo_full_s),
    .nonempty_next (occupied_next_s)
  );

  // Ready comes from the registered full flag: no pop->push bypass
  assign cmd_ready_s   = ~fifo_full_s;
  assign entry_valid_s = ~fifo_empty_s;
`else
  logic hold_valid_q, hold_valid_d;
  cmd_t hold_cmd_q, hold_cmd_d;

  // Holding register: freed by the IDLE pop, so the next command can be
  // taken while the current one is still being strobed
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_cmd_d   = hold_cmd_q;
    if (push_s) begin
      hold_valid_d = 1'b1;
      hold_cmd_d   = in_cmd_s;
    end else if (pop_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Holding register flops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_cmd_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_cmd_q   <= hold_cmd_d;
    end
  end

  assign cmd_ready_s     = ~hold_valid_q;
  assign entry_valid_s   = hold_valid_q;
  assign entry_cmd_s     = hold_cmd_q;
  assign occupied_next_s = hold_valid_d;
`endif

  wr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte1_q, byte1_d;
  logic             pend_q, pend_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             ce_n_q, ce_n_d;
  logic             we_n_q, we_n_d;
  logic             busy_q, busy_d;
  logic             tmo_q, tmo_d;

  // Write sequencer: next state plus next values of the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte1_d = byte1_q;
    pend_d  = pend_q;
    d_out_d = d_out_q;
    tmo_d   = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (entry_valid_s) begin
          pop_s   = 1'b1;
          d_out_d = enc_s.byte0;
          byte1_d = enc_s.byte1;
          pend_d  = enc_s.two_byte;
          cnt_d   = '0;
          state_d = ST_STROBE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        // READY is ignored here: the chip needs time to pull it low
        if (cnt_q == MASK_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_RDY: begin
        if (bus.READY) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (pend_q) begin
            // Data byte follows its latch byte directly; no other command
            // is popped in between
            d_out_d = byte1_q;
            pend_d  = 1'b0;
            state_d = ST_STROBE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Strobe follows the next state, so CE_N/WE_N switch on the same edge
    // as the state change and always together
    ce_n_d = !((state_d == ST_STROBE) || (state_d == ST_WAIT_RDY));
    we_n_d = ce_n_d;
    busy_d = (state_d != ST_IDLE) || occupied_next_s;
  end

  // Sequencer and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      byte1_q <= 8'h00;
      pend_q  <= 1'b0;
      d_out_q <= 8'h00;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte1_q <= byte1_d;
      pend_q  <= pend_d;
      d_out_q <= d_out_d;
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_s;
  assign bus.CE_N          = ce_n_q;
  assign bus.WE_N          = we_n_q;
  assign bus.D_OUT         = d_out_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_error = tmo_q;
endmodule

// File: tb/tb_kf76489_host_writer.sv
// Testbench for kf76489_host_writer: scoreboard of expected bytes filled at
// command acceptance, monitor/chip model checking every strobe, and a
// register-level model of the sound chip compared with the commands issued.
module tb_kf76489_host_writer;
  localparam int MASK  = 2;
  localparam int TMO   = 1023;
  localparam int GAP   = 1;
  localparam int DEPTH = 8;
`ifdef KF76489_WRITER_FIFO_EN
  localparam int EXP_ACC = DEPTH + 1;
`else
  localparam int EXP_ACC = 1;
`endif

  logic clock = 1'b0;
  logic reset;

  kf76489_host_writer_if bus();

  kf76489_host_writer #(
    .READY_MASK_CYCLES (MASK),
    .TIMEOUT_CYCLES    (TMO),
    .GAP_CYCLES        (GAP),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // Reference register contents (from commands) and chip view (from bytes)
  logic [9:0] ref_tone[3];
  logic [9:0] chip_tone[3];
  logic [3:0] ref_atten[4];
  logic [3:0] chip_atten[4];
  logic [2:0] ref_noise, chip_noise;
  logic [1:0] chip_lch;
  logic       chip_ltype;

  int rdy_delay  = 4;
  bit rdy_rand   = 1'b0;
  bit rdy_stuck  = 1'b0;
  int tmo_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 3; i++) begin
      ref_tone[i]  = 10'h000;
      chip_tone[i] = 10'h000;
    end
    for (int i = 0; i < 4; i++) begin
      ref_atten[i]  = 4'h0;
      chip_atten[i] = 4'h0;
    end
    ref_noise  = 3'h0;
    chip_noise = 3'h0;
    chip_lch   = 2'd0;
    chip_ltype = 1'b0;
  endtask

  // Expected bytes and register effect of one accepted command
  task automatic push_expected(input logic [1:0] ch, input logic at, input logic [9:0] val);
    if (at) begin
      exp_q.push_back({1'b1, ch, 1'b1, val[3:0]});
      ref_atten[ch] = val[3:0];
    end else if (ch == 2'd3) begin
      exp_q.push_back({1'b1, 2'b11, 1'b0, 1'b0, val[2:0]});
      ref_noise = val[2:0];
    end else begin
      exp_q.push_back({1'b1, ch, 1'b0, val[3:0]});
      exp_q.push_back({2'b00, val[9:4]});
      ref_tone[ch] = val;
    end
  endtask

  // Called at a negedge; returns one negedge after the accepting edge
  task automatic send_cmd(input logic [1:0] ch, input logic at, input logic [9:0] val);
    int w;
    w = 0;
    bus.cmd_channel = ch;
    bus.cmd_atten   = at;
    bus.cmd_value   = val;
    bus.cmd_valid   = 1'b1;
    while (!bus.cmd_ready && w < 3000) begin
      @(negedge clock);
      w++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
    end else begin
      push_expected(ch, at, val);
      @(negedge clock);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit, input string name);
    int w;
    w = 0;
    while ((bus.busy || exp_q.size() != 0 || !bus.CE_N) && w < limit) begin
      @(negedge clock);
      w++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  // Monitor plus KF76489 model: READY drops one cycle into a strobe and
  // returns cur_d cycles later; each strobe start pops the scoreboard
  initial begin
    bit         prev_ce;
    bit         rise, fall;
    bit         cur_stuck;
    int         age, low_len, high_len, cur_d, exp_len;
    logic [7:0] sbyte;
    prev_ce = 1'b1; age = 0; low_len = 0; high_len = 1000; cur_d = 0;
    cur_stuck = 1'b0; sbyte = 8'h00;
    bus.READY = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus.READY = 1'b1;
        prev_ce   = 1'b1;
        age       = 0;
        low_len   = 0;
        high_len  = 1000;
      end else begin
        rise = prev_ce && !bus.CE_N ? 1'b0 : (!prev_ce && bus.CE_N);
        fall = prev_ce && !bus.CE_N;
        if (bus.timeout_error) tmo_pulses++;
        if (fall) begin
          cur_d     = rdy_rand ? int'($urandom_range(28, 36)) : rdy_delay;
          cur_stuck = rdy_stuck;
          check("gap_len_ok", 32'(high_len >= 1 + GAP), 32'd1);
          check("we_eq_ce_fall", 32'(bus.WE_N), 32'(bus.CE_N));
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", 32'(bus.D_OUT), 32'hFFFF_FFFF);
          end else begin
            check("strobe_byte", 32'(bus.D_OUT), 32'(exp_q.pop_front()));
          end
          sbyte = bus.D_OUT;
          if (sbyte[7]) begin
            chip_lch   = sbyte[6:5];
            chip_ltype = sbyte[4];
            if (sbyte[4]) chip_atten[sbyte[6:5]] = sbyte[3:0];
            else if (sbyte[6:5] == 2'd3) chip_noise = sbyte[2:0];
            else chip_tone[sbyte[6:5]][3:0] = sbyte[3:0];
          end else if (!chip_ltype && chip_lch != 2'd3) begin
            chip_tone[chip_lch][9:4] = sbyte[5:0];
          end
          age     = 0;
          low_len = 0;
        end
        if (!bus.CE_N) begin
          age++;
          low_len++;
          check("d_out_stable", 32'(bus.D_OUT), 32'(sbyte));
        end
        if (rise) begin
          exp_len = cur_stuck ? (MASK + TMO) : ((cur_d + 1 > MASK + 1) ? cur_d + 1 : MASK + 1);
          check("strobe_len", 32'(low_len), 32'(exp_len));
          check("timeout_flag", 32'(bus.timeout_error), 32'(cur_stuck));
          check("we_eq_ce_rise", 32'(bus.WE_N), 32'(bus.CE_N));
          check("d_out_release", 32'(bus.D_OUT), 32'(sbyte));
          high_len = 0;
        end else if (bus.timeout_error) begin
          check("timeout_stray", 32'(bus.timeout_error), 32'd0);
        end
        if (bus.CE_N) high_len++;
        bus.READY = rdy_stuck ? 1'b0 : !(!bus.CE_N && age >= 1 && age <= cur_d);
        prev_ce = bus.CE_N;
      end
    end
  end

  initial begin
    int         acc, p0, w;
    logic [1:0] ch;
    logic       at;
    logic [9:0] val;

    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_channel = 2'd0;
    bus.cmd_atten   = 1'b0;
    bus.cmd_value   = 10'h000;
    clear_models();
    repeat (3) @(negedge clock);
    check("rst_ce_n", 32'(bus.CE_N), 32'd1);
    check("rst_we_n", 32'(bus.WE_N), 32'd1);
    check("rst_d_out", 32'(bus.D_OUT), 32'h00);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout_error), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Two-byte frequency write, READY back after 4 cycles
    rdy_delay = 4;
    send_cmd(2'd0, 1'b0, 10'h3FE);
    wait_idle(500, "t1_idle");

    // Single-byte attenuation and noise-control writes
    send_cmd(2'd2, 1'b1, 10'h005);
    send_cmd(2'd3, 1'b0, 10'h004);
    wait_idle(500, "t2_idle");

    // READY stuck low: forced release after the timeout, one error pulse
    rdy_stuck = 1'b1;
    p0 = tmo_pulses;
    send_cmd(2'd1, 1'b1, 10'($urandom_range(0, 1023)));
    wait_idle(2000, "t3_idle");
    check("t3_tmo_pulses", 32'(tmo_pulses - p0), 32'd1);
    check("t3_ce_n", 32'(bus.CE_N), 32'd1);
    rdy_stuck = 1'b0;

    // Back-to-back pushes against a slow chip: buffering limit and order
    rdy_delay = 40;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.cmd_ready) break;
      ch  = 2'($urandom_range(0, 3));
      at  = 1'($urandom_range(0, 1));
      val = 10'($urandom_range(0, 1023));
      bus.cmd_channel = ch;
      bus.cmd_atten   = at;
      bus.cmd_value   = val;
      bus.cmd_valid   = 1'b1;
      push_expected(ch, at, val);
      acc++;
      @(negedge clock);
    end
    bus.cmd_valid = 1'b0;
    check("t4_accepts", 32'(acc), 32'(EXP_ACC));
    send_cmd(2'd1, 1'b0, 10'h2A5);
    check("t4_accept_during_write", 32'(bus.CE_N), 32'd0);
    wait_idle(8000, "t4_idle");

    // Reset while waiting for READY on byte0 of a frequency write
    rdy_delay = 40;
    send_cmd(2'd1, 1'b0, 10'($urandom_range(16, 1023)));
    w = 0;
    while (bus.CE_N && w < 100) begin
      @(negedge clock);
      w++;
    end
    check("t5_strobe_seen", 32'(bus.CE_N), 32'd0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    check("t5_ce_n", 32'(bus.CE_N), 32'd1);
    check("t5_we_n", 32'(bus.WE_N), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_d_out", 32'(bus.D_OUT), 32'h00);
    exp_q.delete();
    clear_models();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    check("t5_ce_n_after", 32'(bus.CE_N), 32'd1);
    check("t5_busy_after", 32'(bus.busy), 32'd0);

    // Compliance: random commands against a READY ~32 cycles chip model
    rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
    end
    wait_idle(10000, "t6_idle");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_tone%0d", i), 32'(chip_tone[i]), 32'(ref_tone[i]));
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_atten%0d", i), 32'(chip_atten[i]), 32'(ref_atten[i]));
    end
    check("t6_noise", 32'(chip_noise), 32'(ref_noise));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
